// File: rtl/branch_predictor.sv
// Bimodal branch predictor: 2-bit saturating counters indexed by pc[IDX_BITS+1:2].
// Define BP_STATS_EN to add the br_count / mispred_count statistics ports.
module branch_predictor #(
  parameter int PCSIZE   = 16,
  parameter int IDX_BITS = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PCSIZE-1:0] if_pc,
  input  logic              if_is_branch,
  output logic              predict_taken,
  input  logic              ex_valid,
  input  logic              ex_is_branch,
  input  logic [PCSIZE-1:0] ex_pc,
  input  logic              ex_pred,
  input  logic              ex_taken,
  output logic              flushpos,
  output logic              flushneg
`ifdef BP_STATS_EN
  ,
  output logic [15:0]       br_count,
  output logic [15:0]       mispred_count
`endif
);

  localparam int ENTRIES = 1 << IDX_BITS;

  logic [1:0]          ctr [ENTRIES];
  logic [IDX_BITS-1:0] if_idx;
  logic [IDX_BITS-1:0] ex_idx;
  logic                train;
  logic                unused_pc_bits;

  assign if_idx = if_pc[IDX_BITS+1:2];
  assign ex_idx = ex_pc[IDX_BITS+1:2];
  assign train  = ex_valid & ex_is_branch;

  // Untagged table: only the index bits of either PC matter.
  assign unused_pc_bits = ^{if_pc[PCSIZE-1:IDX_BITS+2], if_pc[1:0],
                            ex_pc[PCSIZE-1:IDX_BITS+2], ex_pc[1:0]};

  // Read uses the stored value only, so a same-cycle update is seen one cycle later.
  assign predict_taken = rst_n & if_is_branch & ctr[if_idx][1];
  assign flushpos      = rst_n & ex_valid & ex_is_branch & ex_taken & ~ex_pred;
  assign flushneg      = rst_n & ex_valid & ex_pred & (~ex_is_branch | ~ex_taken);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr[i] <= 2'b01;
      end
    end else if (train) begin
      if (ex_taken) begin
        if (ctr[ex_idx] != 2'b11) begin
          ctr[ex_idx] <= ctr[ex_idx] + 2'd1;
        end
      end else if (ctr[ex_idx] != 2'b00) begin
        ctr[ex_idx] <= ctr[ex_idx] - 2'd1;
      end
    end
  end

`ifdef BP_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_count      <= 16'h0000;
      mispred_count <= 16'h0000;
    end else begin
      if (train && br_count != 16'hFFFF) begin
        br_count <= br_count + 16'h0001;
      end
      if ((flushpos | flushneg) && mispred_count != 16'hFFFF) begin
        mispred_count <= mispred_count + 16'h0001;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed scenarios plus random traffic against an array-of-ints model.
// Build with +define+BP_STATS_EN to also check the statistics counters.
module tb_branch_predictor;

  logic        clk;
  logic        rst_n;
  logic [15:0] if_pc;
  logic        if_is_branch;
  logic        predict_taken;
  logic        ex_valid;
  logic        ex_is_branch;
  logic [15:0] ex_pc;
  logic        ex_pred;
  logic        ex_taken;
  logic        flushpos;
  logic        flushneg;
`ifdef BP_STATS_EN
  logic [15:0] br_count;
  logic [15:0] mispred_count;
`endif

  branch_predictor #(.PCSIZE(16), .IDX_BITS(6)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .if_pc(if_pc),
    .if_is_branch(if_is_branch),
    .predict_taken(predict_taken),
    .ex_valid(ex_valid),
    .ex_is_branch(ex_is_branch),
    .ex_pc(ex_pc),
    .ex_pred(ex_pred),
    .ex_taken(ex_taken),
    .flushpos(flushpos),
    .flushneg(flushneg)
`ifdef BP_STATS_EN
    ,
    .br_count(br_count),
    .mispred_count(mispred_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int model [64];
  int m_br;
  int m_mis;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int idx_of(input logic [15:0] pc);
    return (int'(pc) / 4) % 64;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) model[i] = 1;
    m_br  = 0;
    m_mis = 0;
  endtask

  task automatic set_in(input logic [15:0] ipc, input logic ibr, input logic v,
                        input logic br, input logic [15:0] epc, input logic pr,
                        input logic tk);
    if_pc        = ipc;
    if_is_branch = ibr;
    ex_valid     = v;
    ex_is_branch = br;
    ex_pc        = epc;
    ex_pred      = pr;
    ex_taken     = tk;
  endtask

  // Called at a negedge with inputs already applied; checks, then advances one cycle.
  task automatic cycle(input string tag);
    logic exp_pred, exp_fp, exp_fn;
    #1;
    exp_pred = if_is_branch && (model[idx_of(if_pc)] >= 2);
    exp_fp   = ex_valid && ex_is_branch && ex_taken && !ex_pred;
    exp_fn   = ex_valid && ex_pred && (!ex_is_branch || !ex_taken);
    chk({tag, "_pred"}, {31'd0, predict_taken}, {31'd0, exp_pred});
    chk({tag, "_fpos"}, {31'd0, flushpos}, {31'd0, exp_fp});
    chk({tag, "_fneg"}, {31'd0, flushneg}, {31'd0, exp_fn});
`ifdef BP_STATS_EN
    chk({tag, "_brcnt"}, {16'd0, br_count}, m_br);
    chk({tag, "_miscnt"}, {16'd0, mispred_count}, m_mis);
`endif
    @(posedge clk);
    if (ex_valid && ex_is_branch) begin
      if (ex_taken) model[idx_of(ex_pc)] = (model[idx_of(ex_pc)] == 3) ? 3 : model[idx_of(ex_pc)] + 1;
      else          model[idx_of(ex_pc)] = (model[idx_of(ex_pc)] == 0) ? 0 : model[idx_of(ex_pc)] - 1;
      if (m_br < 65535) m_br++;
    end
    if ((exp_fp || exp_fn) && m_mis < 65535) m_mis++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic train(input logic [15:0] pc, input logic tk, input int n);
    for (int i = 0; i < n; i++) begin
      set_in(16'h0000, 1'b0, 1'b1, 1'b1, pc, 1'b0, tk);
      cycle("train");
    end
  endtask

  task automatic probe(input string tag, input logic [15:0] pc, input logic exp);
    set_in(pc, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    #1;
    chk(tag, {31'd0, predict_taken}, {31'd0, exp});
    cycle(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    model_reset();
    set_in(16'h0040, 1'b1, 1'b1, 1'b1, 16'h0040, 1'b0, 1'b1);
    #2;
    chk("rst_pred", {31'd0, predict_taken}, 32'd0);
    chk("rst_fpos", {31'd0, flushpos}, 32'd0);
    chk("rst_fneg", {31'd0, flushneg}, 32'd0);
`ifdef BP_STATS_EN
    chk("rst_brcnt", {16'd0, br_count}, 32'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: whole table predicts not-taken after reset
    for (int pc = 0; pc <= 16'h00FC; pc += 4) begin
      set_in(16'(pc), 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
      cycle("t1");
    end

    // 2: two taken saturate, alias shares counter, neighbour untouched
    train(16'h0040, 1'b1, 2);
    probe("t2_hit", 16'h0040, 1'b1);
    probe("t2_alias", 16'h0140, 1'b1);
    probe("t2_other", 16'h0044, 1'b0);

    // 3: hysteresis from saturated strong taken
    do_reset();
    train(16'h0040, 1'b1, 5);
    train(16'h0040, 1'b0, 1);
    probe("t3_wt", 16'h0040, 1'b1);
    train(16'h0040, 1'b0, 1);
    probe("t3_wnt", 16'h0040, 1'b0);

    // 4: saturate at zero, one taken only reaches weakly not-taken
    do_reset();
    train(16'h0080, 1'b0, 4);
    train(16'h0080, 1'b1, 1);
    probe("t4_wnt", 16'h0080, 1'b0);
    train(16'h0080, 1'b1, 1);
    probe("t4_wt", 16'h0080, 1'b1);

    // 5: flush generation
    set_in(16'h0000, 1'b0, 1'b1, 1'b1, 16'h0010, 1'b0, 1'b1);
    #1;
    chk("t5_fpos", {30'd0, flushpos, flushneg}, 32'd2);
    cycle("t5a");
    set_in(16'h0000, 1'b0, 1'b1, 1'b0, 16'h0020, 1'b1, 1'b1);
    #1;
    chk("t5_fneg", {30'd0, flushpos, flushneg}, 32'd1);
    cycle("t5b");
    probe("t5_notrain", 16'h0020, 1'b0);
    train(16'h0020, 1'b1, 1);
    probe("t5_ctr1", 16'h0020, 1'b1);
    set_in(16'h0000, 1'b0, 1'b0, 1'b1, 16'h0030, 1'b1, 1'b0);
    #1;
    chk("t5_bubble", {30'd0, flushpos, flushneg}, 32'd0);
    cycle("t5c");

    // 6: same-cycle read/write sees the old value
    do_reset();
    set_in(16'h0040, 1'b1, 1'b1, 1'b1, 16'h0040, 1'b0, 1'b1);
    #1;
    chk("t6_same", {31'd0, predict_taken}, 32'd0);
    cycle("t6a");
    probe("t6_next", 16'h0040, 1'b1);

    // random traffic over a small PC window to get plenty of hits and aliases
    for (int n = 0; n < 400; n++) begin
      set_in(16'($urandom & 32'h03FF), 1'($urandom), 1'($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 4) != 0), 16'($urandom & 32'h03FF),
             1'($urandom), 1'($urandom));
      cycle("rnd");
    end

    // mid-run async reset with flush-causing inputs and a trained entry
    train(16'h0040, 1'b1, 3);
    set_in(16'h0040, 1'b1, 1'b1, 1'b1, 16'h0040, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("mid_pred", {31'd0, predict_taken}, 32'd0);
    chk("mid_fneg", {31'd0, flushneg}, 32'd0);
`ifdef BP_STATS_EN
    chk("mid_brcnt", {16'd0, br_count}, 32'd0);
    chk("mid_miscnt", {16'd0, mispred_count}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    probe("mid_after", 16'h0040, 1'b0);
    train(16'h0040, 1'b1, 1);
    probe("mid_ctr1", 16'h0040, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
